// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its 8-bit datapath.
// The FSM side uses the master modport; the datapath side uses the slave modport.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       ior_d;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero,
    output pc_en, pc_src, ior_d, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, illegal, state
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_en, pc_src, ior_d, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, illegal, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and drives the 8-bit datapath mux selects, write enables and ALU op code.
module mc_control_fsm (
  input  logic             clock,
  input  logic             reset,
  mc_control_fsm_if.master ctrl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ      = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  state_t state_q, state_d;
  logic   is_load_q, is_load_d;

  logic       funct_legal;
  logic [3:0] rtype_alu_op;

  logic       pc_en_c;
  logic [1:0] pc_src_c;
  logic       ior_d_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       reg_write_c;
  logic       reg_dst_c;
  logic       mem_to_reg_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [3:0] alu_op_c;
  logic       instr_done_c;
  logic       illegal_c;

  // lw/sw choice is captured in DECODE so opcode is never looked at in MEMADR.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
    end
  end

  always_comb begin
    funct_legal  = 1'b1;
    rtype_alu_op = 4'd0;
    case (ctrl.funct)
      FN_ADD:  rtype_alu_op = ALU_ADD;
      FN_SUB:  rtype_alu_op = ALU_SUB;
      FN_AND:  rtype_alu_op = ALU_AND;
      FN_OR:   rtype_alu_op = ALU_OR;
      FN_NOR:  rtype_alu_op = ALU_NOR;
      FN_SLT:  rtype_alu_op = ALU_SLT;
      default: funct_legal  = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = FETCH;
    is_load_d    = is_load_q;
    pc_en_c      = 1'b0;
    pc_src_c     = 2'b00;
    ior_d_c      = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 4'd0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;

    case (state_q)
      FETCH: begin
        ir_write_c  = 1'b1;
        alu_src_b_c = 2'b01;
        alu_op_c    = ALU_ADD;
        pc_src_c    = 2'b00;
        pc_en_c     = 1'b1;
        state_d     = DECODE;
      end
      DECODE: begin
        alu_src_b_c = 2'b11;
        alu_op_c    = ALU_ADD;
        case (ctrl.opcode)
          OP_LW: begin
            state_d   = MEMADR;
            is_load_d = 1'b1;
          end
          OP_SW: begin
            state_d   = MEMADR;
            is_load_d = 1'b0;
          end
          OP_RTYPE: begin
            if (funct_legal) state_d   = RTYPE_EX;
            else             illegal_c = 1'b1;
          end
          OP_BEQ:  state_d   = BEQ;
          OP_ADDI: state_d   = ADDI_EX;
          OP_J:    state_d   = JUMP;
          default: illegal_c = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = ALU_ADD;
        state_d     = is_load_q ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ior_d_c = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        instr_done_c = 1'b1;
      end
      MEMWR: begin
        ior_d_c      = 1'b1;
        mem_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      RTYPE_EX: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = rtype_alu_op;
        state_d     = RTYPE_WB;
      end
      RTYPE_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = 1'b1;
        instr_done_c = 1'b1;
      end
      BEQ: begin
        alu_src_a_c  = 1'b1;
        alu_op_c     = ALU_SUB;
        pc_src_c     = 2'b01;
        pc_en_c      = ctrl.zero;
        instr_done_c = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = ALU_ADD;
        state_d     = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      JUMP: begin
        pc_src_c     = 2'b10;
        pc_en_c      = 1'b1;
        instr_done_c = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset blanks every output immediately, before the synchronous edge lands.
  assign ctrl.pc_en      = reset ? 1'b0  : pc_en_c;
  assign ctrl.pc_src     = reset ? 2'b00 : pc_src_c;
  assign ctrl.ior_d      = reset ? 1'b0  : ior_d_c;
  assign ctrl.mem_write  = reset ? 1'b0  : mem_write_c;
  assign ctrl.ir_write   = reset ? 1'b0  : ir_write_c;
  assign ctrl.reg_write  = reset ? 1'b0  : reg_write_c;
  assign ctrl.reg_dst    = reset ? 1'b0  : reg_dst_c;
  assign ctrl.mem_to_reg = reset ? 1'b0  : mem_to_reg_c;
  assign ctrl.alu_src_a  = reset ? 1'b0  : alu_src_a_c;
  assign ctrl.alu_src_b  = reset ? 2'b00 : alu_src_b_c;
  assign ctrl.alu_op     = reset ? 4'd0  : alu_op_c;
  assign ctrl.instr_done = reset ? 1'b0  : instr_done_c;
  assign ctrl.illegal    = reset ? 1'b0  : illegal_c;
  assign ctrl.state      = reset ? 4'd0  : state_q;

endmodule
